// File: rtl/rib_arbiter.sv
// rtl/rib_arbiter.sv - sequential RIB bus arbiter with burst limit and no-ack timeout
module rib_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int CORE_IDX  = 3,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 64,
    localparam int ID_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] req_i,
    input  logic                 ack_i,
    output logic [N_MASTERS-1:0] grant_o,
    output logic [ID_W-1:0]      grant_id_o,
    output logic                 busy_o,
    output logic                 hold_flag_rib_o,
    output logic                 timeout_o
);

    localparam int BEAT_W = $clog2(MAX_BURST) + 1;
    localparam int WAIT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic                 busy_q, busy_d;
    logic                 to_q, to_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [N_MASTERS-1:0] skip_q, skip_d;

    logic [N_MASTERS-1:0] cand;
    logic                 win_found;
    logic [ID_W-1:0]      win_idx;
    logic                 owner_req;
    logic                 others_req;
    logic                 beat_max;
    logic                 wait_max;

    // Fixed-priority pick among requesters, skipping a just-demoted master unless it is the only one asking
    always_comb begin
        cand = req_i & ~skip_q;
        if (cand == '0) begin
            cand = req_i;
        end
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(i);
            end
        end
    end

    assign owner_req  = |(req_i & grant_q);
    assign others_req = |(req_i & ~grant_q);
    assign beat_max   = (beat_q == BEAT_W'(MAX_BURST - 1));
    assign wait_max   = (wait_q == WAIT_W'(TIMEOUT - 1));

    // Next-state and registered-output logic; owner release order is req drop, then burst limit, then timeout
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        busy_d  = busy_q;
        to_d    = 1'b0;
        beat_d  = beat_q;
        wait_d  = wait_q;
        skip_d  = skip_q;

        case (state_q)
            S_IDLE: begin
                skip_d  = '0;
                grant_d = '0;
                id_d    = '0;
                busy_d  = 1'b0;
                if (win_found) begin
                    state_d = S_GRANT;
                    grant_d = N_MASTERS'(1) << win_idx;
                    id_d    = win_idx;
                    busy_d  = 1'b1;
                    beat_d  = '0;
                    wait_d  = '0;
                end
            end

            S_GRANT: begin
                if (ack_i) begin
                    wait_d = '0;
                    if (!beat_max) begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end else if (!wait_max) begin
                    wait_d = wait_q + WAIT_W'(1);
                end

                if (!owner_req) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    id_d    = '0;
                    busy_d  = 1'b0;
                end else if (ack_i && beat_max && others_req) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    id_d    = '0;
                    busy_d  = 1'b0;
                    skip_d  = grant_q;
                end else if (!ack_i && wait_max) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    id_d    = '0;
                    busy_d  = 1'b0;
                    skip_d  = grant_q;
                    to_d    = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                id_d    = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops the grant immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
            beat_q  <= '0;
            wait_q  <= '0;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            skip_q  <= skip_d;
        end
    end

    assign grant_o         = grant_q;
    assign grant_id_o      = id_q;
    assign busy_o          = busy_q;
    assign timeout_o       = to_q;
    assign hold_flag_rib_o = req_i[CORE_IDX] & ~grant_q[CORE_IDX];

endmodule

// File: tb/tb_rib_arbiter.sv
// tb/tb_rib_arbiter.sv - scoreboard bench for rib_arbiter against a behavioural arbitration model
module tb_rib_arbiter;

    localparam int MAX_BURST = 8;
    localparam int TIMEOUT   = 64;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic [3:0] grant_o;
    logic [1:0] grant_id_o;
    logic       busy_o;
    logic       hold_flag_rib_o;
    logic       timeout_o;

    rib_arbiter #(
        .N_MASTERS(4),
        .CORE_IDX (3),
        .MAX_BURST(MAX_BURST),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req),
        .ack_i          (ack),
        .grant_o        (grant_o),
        .grant_id_o     (grant_id_o),
        .busy_o         (busy_o),
        .hold_flag_rib_o(hold_flag_rib_o),
        .timeout_o      (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] id;
        logic       busy;
        logic       to;
        logic       hold;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_err    = 0;

    // Behavioural model: who owns the bus, how many acks and consecutive silent cycles it has seen
    int       m_owner = -1;
    int       m_acks  = 0;
    int       m_waits = 0;
    bit [3:0] m_skip  = '0;
    bit       m_to    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_acks  = 0;
        m_waits = 0;
        m_skip  = '0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic a);
        int pick;
        int g;
        m_to = 1'b0;
        if (m_owner < 0) begin
            pick = -1;
            for (int i = 3; i >= 0; i--) if (r[i] && !m_skip[i]) pick = i;
            if (pick < 0) for (int i = 3; i >= 0; i--) if (r[i]) pick = i;
            m_skip = '0;
            if (pick >= 0) begin
                m_owner = pick;
                m_acks  = 0;
                m_waits = 0;
            end
        end else begin
            g = m_owner;
            if (!r[g]) begin
                m_owner = -1;
            end else if (a && m_acks >= MAX_BURST - 1 && (r & ~(4'b0001 << g)) != 4'b0000) begin
                m_owner   = -1;
                m_skip[g] = 1'b1;
            end else if (!a && m_waits >= TIMEOUT - 1) begin
                m_owner   = -1;
                m_skip[g] = 1'b1;
                m_to      = 1'b1;
            end
            if (a) begin
                m_acks++;
                m_waits = 0;
            end else begin
                m_waits++;
            end
        end
    endtask

    // Called at a falling edge: apply inputs, predict the state after the next rising edge, wait one cycle
    task automatic drive(input logic [3:0] r, input logic a);
        exp_t e;
        req = r;
        ack = a;
        model_step(r, a);
        e.grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.id    = (m_owner >= 0) ? 2'(m_owner) : 2'b00;
        e.busy  = (m_owner >= 0);
        e.to    = m_to;
        e.hold  = r[3] & ~e.grant[3];
        q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: after every rising edge compare the DUT against the oldest prediction
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("grant", 32'(grant_o), 32'(mon_e.grant));
            check("busy", 32'(busy_o), 32'(mon_e.busy));
            check("timeout", 32'(timeout_o), 32'(mon_e.to));
            check("hold", 32'(hold_flag_rib_o), 32'(mon_e.hold));
            check("onehot", 32'($onehot0(grant_o)), 32'd1);
            if (mon_e.busy) check("grant_id", 32'(grant_id_o), 32'(mon_e.id));
        end
    end

    logic [3:0] rr;
    logic       ra;

    initial begin
        rst = 1'b0;
        req = 4'b1000;
        ack = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        check("rst_hold", 32'(hold_flag_rib_o), 32'd1);

        // Core alone after reset release
        rst = 1'b1;
        drive(4'b1000, 1'b0);
        drive(4'b1000, 1'b1);
        drive(4'b0000, 1'b0);
        drive(4'b0000, 1'b0);

        // Master 0 beats core, then core gets the bus after one bubble
        drive(4'b1001, 1'b0);
        drive(4'b1001, 1'b1);
        drive(4'b1001, 1'b1);
        drive(4'b1000, 1'b0);
        drive(4'b1000, 1'b0);
        drive(4'b1000, 1'b1);
        drive(4'b0000, 1'b0);
        drive(4'b0000, 1'b0);

        // Burst limit with core waiting, then master 1 alone never loses the bus
        repeat (12) drive(4'b1010, 1'b1);
        drive(4'b0000, 1'b0);
        drive(4'b0000, 1'b0);
        repeat (22) drive(4'b0010, 1'b1);
        drive(4'b0000, 1'b0);
        drive(4'b0000, 1'b0);

        // Timeout on master 2, with and without a competitor
        repeat (70) drive(4'b0100, 1'b0);
        repeat (70) drive(4'b0110, 1'b0);
        drive(4'b0000, 1'b0);
        drive(4'b0000, 1'b0);

        // Asynchronous reset in the middle of a grant
        for (int i = 0; i < 5; i++) drive(4'b0100, 1'(i % 2));
        @(posedge clk);
        #3;
        rst = 1'b0;
        ack = 1'b1;
        #1;
        check("arst_grant", 32'(grant_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_timeout", 32'(timeout_o), 32'd0);
        check("arst_hold", 32'(hold_flag_rib_o), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        drive(4'b1100, 1'b0);
        drive(4'b1100, 1'b1);

        // Owner drop coinciding with ack
        drive(4'b0000, 1'b0);
        drive(4'b0001, 1'b0);
        drive(4'b0001, 1'b1);
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b0);

        // Random traffic with occasional long silent-slave windows
        rr = 4'b0000;
        for (int c = 0; c < 1000; c++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) rr[b] = ~rr[b];
            if ((c % 250) >= 170) ra = 1'b0;
            else ra = ($urandom_range(0, 2) != 0);
            drive(rr, ra);
        end

        repeat (2) @(negedge clk);
        check("drain", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
